// File: rtl/sum_round_engine.sv
// Sum-guessing round engine: LFSR-scrambled target, two edge-captured operands,
// single-cycle scoring with a limited number of tries per game.
module sum_round_engine #(
    parameter int unsigned W         = 4,
    parameter int unsigned MAX_TRIES = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld1,
    input  logic           ld2,
    input  logic           new_game,
    input  logic [W-1:0]   data_in,
    output logic [W-1:0]   operand_a,
    output logic [W-1:0]   operand_b,
    output logic [W:0]     sum,
    output logic [W:0]     target,
    output logic [3:0]     tries_left,
    output logic           wait_a,
    output logic           wait_b,
    output logic           win_led,
    output logic           lose_led
);

    localparam int unsigned SW = W + 1;
    localparam int unsigned TW = 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_A = 3'd1;
    localparam logic [2:0] WAIT_B = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] WIN    = 3'd4;
    localparam logic [2:0] LOSE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          ld1_q, ld1_d;
    logic          ld2_q, ld2_d;
    logic [W-1:0]  operand_a_q, operand_a_d;
    logic [W-1:0]  operand_b_q, operand_b_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] target_q, target_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          wait_a_q, wait_a_d;
    logic          wait_b_q, wait_b_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;

    logic          rise1_c;
    logic          rise2_c;
    logic [7:0]    lfsr_step_c;
    logic [SW-1:0] target_new_c;
    logic [SW-1:0] sum_new_c;

    // A held level yields a single event on its first cycle.
    assign rise1_c = ld1 & ~ld1_q;
    assign rise2_c = ld2 & ~ld2_q;

    assign lfsr_step_c  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign target_new_c = SW'(lfsr_q[W-1:0]) + SW'(lfsr_q[2*W-1:W]);
    assign sum_new_c    = SW'(operand_a_q) + SW'(operand_b_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            ld1_q       <= 1'b0;
            ld2_q       <= 1'b0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            sum_q       <= '0;
            target_q    <= '0;
            tries_q     <= '0;
            wait_a_q    <= 1'b0;
            wait_b_q    <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            ld1_q       <= ld1_d;
            ld2_q       <= ld2_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            sum_q       <= sum_d;
            target_q    <= target_d;
            tries_q     <= tries_d;
            wait_a_q    <= wait_a_d;
            wait_b_q    <= wait_b_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    // Next-state logic; new_game overrides whatever the round is doing.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        ld1_d       = ld1;
        ld2_d       = ld2;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        sum_d       = sum_q;
        target_d    = target_q;
        tries_d     = tries_q;

        if (new_game) begin
            target_d    = target_new_c;
            lfsr_d      = lfsr_step_c;
            tries_d     = TW'(MAX_TRIES);
            operand_a_d = '0;
            operand_b_d = '0;
            sum_d       = '0;
            state_d     = WAIT_A;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (rise1_c) begin
                        operand_a_d = data_in;
                        state_d     = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rise1_c) begin
                        operand_a_d = data_in;
                    end else if (rise2_c) begin
                        operand_b_d = data_in;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    sum_d = sum_new_c;
                    if (sum_new_c == target_q) begin
                        state_d = WIN;
                    end else begin
                        tries_d = tries_q - TW'(1);
                        state_d = (tries_q == TW'(1)) ? LOSE : WAIT_A;
                    end
                end
                WIN, LOSE, IDLE: state_d = state_q;
                default:         state_d = IDLE;
            endcase
        end

        wait_a_d = (state_d == WAIT_A);
        wait_b_d = (state_d == WAIT_B);
        win_d    = (state_d == WIN);
        lose_d   = (state_d == LOSE);
    end

    assign operand_a  = operand_a_q;
    assign operand_b  = operand_b_q;
    assign sum        = sum_q;
    assign target     = target_q;
    assign tries_left = tries_q;
    assign wait_a     = wait_a_q;
    assign wait_b     = wait_b_q;
    assign win_led    = win_q;
    assign lose_led   = lose_q;

endmodule

// File: tb/tb_sum_round_engine.sv
// Scoreboard bench for sum_round_engine: directed stimulus queues expected
// output snapshots; a negedge monitor pops and compares them.
module tb_sum_round_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld1, ld2, new_game;
    logic [3:0] data_in;
    logic [3:0] operand_a, operand_b, tries_left;
    logic [4:0] sum, target;
    logic       wait_a, wait_b, win_led, lose_led;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    typedef struct {
        string       name;
        logic [25:0] v;
        int unsigned stamp;
    } exp_t;

    exp_t sb[$];

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_WA   = 4'b1000;
    localparam logic [3:0] F_WB   = 4'b0100;
    localparam logic [3:0] F_WIN  = 4'b0010;
    localparam logic [3:0] F_LOSE = 4'b0001;

    sum_round_engine #(.W(4), .MAX_TRIES(3), .LFSR_SEED(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld1        (ld1),
        .ld2        (ld2),
        .new_game   (new_game),
        .data_in    (data_in),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .sum        (sum),
        .target     (target),
        .tries_left (tries_left),
        .wait_a     (wait_a),
        .wait_b     (wait_b),
        .win_led    (win_led),
        .lose_led   (lose_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string show(input logic [25:0] v);
        return $sformatf("a=%0d b=%0d sum=%0d tgt=%0d tries=%0d wa=%0b wb=%0b win=%0b lose=%0b",
                         v[25:22], v[21:18], v[17:13], v[12:8], v[7:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] a, input logic [3:0] b,
                              input logic [4:0] s, input logic [4:0] t, input logic [3:0] tr,
                              input logic [3:0] flags);
        exp_t e;
        e.name  = name;
        e.v     = {a, b, s, t, tr, flags};
        e.stamp = cyc;
        sb.push_back(e);
    endtask

    // Monitor: compares queued expectations stamped for the current cycle.
    initial begin
        logic [25:0] act;
        exp_t        e;
        forever begin
            @(negedge clk);
            act = {operand_a, operand_b, sum, target, tries_left, wait_a, wait_b, win_led, lose_led};
            while (sb.size() > 0 && sb[0].stamp <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.stamp != cyc) begin
                    n_fail++;
                    $display("FAIL %s: sample missed (stamp %0d, cycle %0d)", e.name, e.stamp, cyc);
                end else if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got [%s] expected [%s]", e.name, show(act), show(e.v));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ld1 = 1'b0; ld2 = 1'b0; new_game = 1'b0; data_in = 4'd0;

        // T1: reset values, ld ignored in IDLE
        tick(); tick();
        expect_out("reset", 0, 0, 0, 0, 0, F_NONE);
        rst = 1'b0; ld1 = 1'b1;
        tick(); ld1 = 1'b0; ld2 = 1'b1;
        tick(); ld2 = 1'b0;
        tick();
        expect_out("idle_ld_ignored", 0, 0, 0, 0, 0, F_NONE);

        // T2: LFSR targets A5 -> 15, 4A -> 14
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_first", 0, 0, 0, 15, 3, F_WA);
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_second", 0, 0, 0, 14, 3, F_WA);

        // T3: win with 7 + 8 against target 15
        rst = 1'b1; tick(); rst = 1'b0;
        expect_out("rst_mid_game", 0, 0, 0, 0, 0, F_NONE);
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_seed", 0, 0, 0, 15, 3, F_WA);
        data_in = 4'd7; ld1 = 1'b1; tick(); ld1 = 1'b0;
        expect_out("a_capture", 7, 0, 0, 15, 3, F_WB);
        data_in = 4'd8; ld2 = 1'b1; tick(); ld2 = 1'b0;
        expect_out("b_capture", 7, 8, 0, 15, 3, F_NONE);
        tick();
        expect_out("win", 7, 8, 15, 15, 3, F_WIN);
        data_in = 4'd1; ld1 = 1'b1; tick(); ld1 = 1'b0; ld2 = 1'b1; tick(); ld2 = 1'b0; tick();
        expect_out("win_hold", 7, 8, 15, 15, 3, F_WIN);

        // T4: three losing attempts of 3 + 3
        rst = 1'b1; tick(); rst = 1'b0;
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_lose_game", 0, 0, 0, 15, 3, F_WA);
        data_in = 4'd3;
        for (int i = 0; i < 3; i++) begin
            ld1 = 1'b1; tick(); ld1 = 1'b0; tick();
            ld2 = 1'b1; tick(); ld2 = 1'b0; tick();
            if (i < 2) expect_out($sformatf("miss_%0d", i), 3, 3, 6, 15, 4'(2 - i), F_WA);
            else       expect_out("lose", 3, 3, 6, 15, 0, F_LOSE);
        end
        data_in = 4'd9; ld1 = 1'b1; tick(); ld1 = 1'b0; ld2 = 1'b1; tick(); ld2 = 1'b0; tick();
        expect_out("lose_hold", 3, 3, 6, 15, 0, F_LOSE);

        // T5: held level and simultaneous rises; lfsr 4A -> target 14
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_from_lose", 0, 0, 0, 14, 3, F_WA);
        data_in = 4'd9; ld1 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        expect_out("held_ld1", 9, 0, 0, 14, 3, F_WB);
        ld1 = 1'b0; tick();
        data_in = 4'd2; ld1 = 1'b1; ld2 = 1'b1; tick(); ld1 = 1'b0; ld2 = 1'b0;
        expect_out("simul_rise", 2, 0, 0, 14, 3, F_WB);
        tick();

        // T6: new_game in WAIT_B (lfsr 95 -> 14), then 2A -> 12; rst during CHECK
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_in_wait_b", 0, 0, 0, 14, 3, F_WA);
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("ng_target12", 0, 0, 0, 12, 3, F_WA);
        data_in = 4'd12; ld1 = 1'b1; tick(); ld1 = 1'b0;
        data_in = 4'd0; ld2 = 1'b1; tick(); ld2 = 1'b0;
        expect_out("check_state", 12, 0, 0, 12, 3, F_NONE);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_out("rst_in_check", 0, 0, 0, 0, 0, F_NONE);
        tick();
        expect_out("post_rst_idle", 0, 0, 0, 0, 0, F_NONE);
        new_game = 1'b1; tick(); new_game = 1'b0;
        expect_out("seed_repeat", 0, 0, 0, 15, 3, F_WA);

        tick(); tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation never sampled (stamp %0d)", e.name, e.stamp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
